// File: rtl/binary_sub_serial.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, with a single borrow flop.
// Optional signed-overflow output V is enabled by defining BINARY_SUB_OVERFLOW_EN.
module binary_sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
`ifdef BINARY_SUB_OVERFLOW_EN
    output logic             done,
    output logic             V
`else
    output logic             done
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             borrow;

    logic bit_a;
    logic bit_b;
    logic diff_bit;
    logic borrow_nxt;
    logic last_bit;

    // The single full-subtractor cell shared by every bit position.
    assign bit_a      = sa[0];
    assign bit_b      = sb[0];
    assign diff_bit   = bit_a ^ bit_b ^ borrow;
    assign borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
    assign last_bit   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: default assignment first so no path through the case leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef BINARY_SUB_OVERFLOW_EN
    logic a_msb;
    logic b_msb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
`ifdef BINARY_SUB_OVERFLOW_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            V      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        sa     <= A;
                        sb     <= B;
                        sr     <= '0;
                        cnt    <= '0;
                        borrow <= 1'b0;
`ifdef BINARY_SUB_OVERFLOW_EN
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    sr     <= {diff_bit, sr[WIDTH-1:1]};
                    borrow <= borrow_nxt;
                    // Counter parks at WIDTH-1 instead of wrapping.
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        D    <= {diff_bit, sr[WIDTH-1:1]};
                        Bout <= borrow_nxt;
`ifdef BINARY_SUB_OVERFLOW_EN
                        V    <= (a_msb ^ b_msb) & (diff_bit ^ a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
